// File: rtl/cdb_arbiter.sv
`default_nettype none
// -------------------------------------------------------------------------
// cdb_arbiter : round-robin Common Data Bus arbiter with registered
//               broadcast and saturating contention counter.   Rev 1.0
// -------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int TAG_W = 6,
  parameter  int CNT_W = 16,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [SRC_W-1:0]       cdb_src,
  output logic [CNT_W-1:0]       conflict_cnt
);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_en;
  logic [TAG_W-1:0] grant_tag;
  logic [SRC_W:0]   n_valid;
  logic             conflict;

  // Scan from rr_ptr with an explicit wrap so N_REQ need not be a power of 2.
  always_comb begin : grant_scan
    logic [SRC_W:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(N_REQ)) begin
        idx = idx - (SRC_W+1)'(N_REQ);
      end
      if (!grant_any && req_valid[idx[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    grant_tag = '0;
    n_valid   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == SRC_W'(k)) begin
        grant_tag = req_tag[k*TAG_W +: TAG_W];
      end
      n_valid = n_valid + (SRC_W+1)'(req_valid[k]);
    end
  end

  // The reset term keeps ready low while the async reset is held.
  assign grant_en = grant_any && !squash && reset;
  assign conflict = (n_valid >= (SRC_W+1)'(2)) && !squash;

  always_comb begin
    req_ready   = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_src_d   = cdb_src_q;
    cnt_d       = cnt_q;
    if (grant_en) begin
      req_ready[grant_idx] = 1'b1;
      rr_ptr_d    = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      cdb_valid_d = 1'b1;
      cdb_tag_d   = grant_tag;
      cdb_src_d   = grant_idx;
    end
    if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_src_q   <= cdb_src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// -------------------------------------------------------------------------
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter.  Rev 1.0
// -------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic        squash;
  logic [3:0]  req_valid;
  logic [23:0] req_tag;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [1:0]  cdb_src;
  logic [15:0] conflict_cnt;

  // Narrow-counter copy sharing the same stimulus, to reach saturation quickly.
  logic [3:0]  s_req_ready;
  logic        s_cdb_valid;
  logic [5:0]  s_cdb_tag;
  logic [1:0]  s_cdb_src;
  logic [1:0]  s_conflict_cnt;

  int tests = 0;
  int fails = 0;

  cdb_arbiter #(.N_REQ(4), .TAG_W(6), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );

  cdb_arbiter #(.N_REQ(4), .TAG_W(6), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(s_req_ready),
    .cdb_valid(s_cdb_valid), .cdb_tag(s_cdb_tag), .cdb_src(s_cdb_src),
    .conflict_cnt(s_conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #3;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b exp 0000", req_ready); end
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", cdb_valid); end
    tests++; if (cdb_tag !== 6'd0) begin fails++; $display("FAIL rst_tag: got %0d exp 0", cdb_tag); end
    tests++; if (cdb_src !== 2'd0) begin fails++; $display("FAIL rst_src: got %0d exp 0", cdb_src); end
    tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0h exp 0", conflict_cnt); end
    req_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_tag[0 +: 6] = 6'd5;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    tests++; if (cdb_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", cdb_valid); end
    tests++; if (cdb_tag !== 6'd5) begin fails++; $display("FAIL single_tag: got %0d exp 5", cdb_tag); end
    tests++; if (cdb_src !== 2'd0) begin fails++; $display("FAIL single_src: got %0d exp 0", cdb_src); end
    tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b exp 0", cdb_valid); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_ready;
    do_reset();
    req_tag   = {6'd13, 6'd12, 6'd11, 6'd10};
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp_ready = 4'b0001 << g;
      #1;
      tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL all4_ready[%0d]: got %b exp %b", g, req_ready, exp_ready); end
      tick();
      req_valid[g] = 1'b0;
      tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'(10 + g) || cdb_src !== 2'(g))
        begin fails++; $display("FAIL all4_bcast[%0d]: got v=%b tag=%0d src=%0d exp v=1 tag=%0d src=%0d", g, cdb_valid, cdb_tag, cdb_src, 10 + g, g); end
    end
    tests++; if (conflict_cnt !== 16'd3) begin fails++; $display("FAIL all4_cnt: got %0d exp 3", conflict_cnt); end
    tests++; if (s_conflict_cnt !== 2'd3) begin fails++; $display("FAIL all4_cnt_narrow: got %0d exp 3", s_conflict_cnt); end
    tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL all4_idle: got %b exp 0", cdb_valid); end
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    req_tag[12 +: 6] = 6'd20;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_ready2: got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1001;
    req_tag[18 +: 6] = 6'd23;
    req_tag[0 +: 6]  = 6'd24;
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL wrap_ready3: got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0001;
    tests++; if (cdb_tag !== 6'd23 || cdb_src !== 2'd3) begin fails++; $display("FAIL wrap_bcast3: got tag=%0d src=%0d exp tag=23 src=3", cdb_tag, cdb_src); end
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready0: got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0011;
    req_tag[6 +: 6] = 6'd25;
    tests++; if (cdb_tag !== 6'd24 || cdb_src !== 2'd0) begin fails++; $display("FAIL wrap_bcast0: got tag=%0d src=%0d exp tag=24 src=0", cdb_tag, cdb_src); end
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_ptr1: got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0000;
    tests++; if (conflict_cnt !== 16'd5) begin fails++; $display("FAIL wrap_cnt: got %0d exp 5", conflict_cnt); end
    tests++; if (s_conflict_cnt !== 2'd3) begin fails++; $display("FAIL sat_narrow: got %0d exp 3", s_conflict_cnt); end
  endtask

  task automatic test_squash();
    req_valid = 4'b0010;
    req_tag[6 +: 6] = 6'd31;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL sq_pre_ready: got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0110;
    req_tag[6 +: 6]  = 6'd33;
    req_tag[12 +: 6] = 6'd34;
    squash = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL sq_ready: got %b exp 0000", req_ready); end
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd31) begin fails++; $display("FAIL sq_prior_bcast: got v=%b tag=%0d exp v=1 tag=31", cdb_valid, cdb_tag); end
    tick();
    squash = 1'b0;
    tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 6'd31 || cdb_src !== 2'd1)
      begin fails++; $display("FAIL sq_after: got v=%b tag=%0d src=%0d exp v=0 tag=31 src=1", cdb_valid, cdb_tag, cdb_src); end
    tests++; if (conflict_cnt !== 16'd5) begin fails++; $display("FAIL sq_cnt: got %0d exp 5", conflict_cnt); end
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL sq_ptr: got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0010;
    tests++; if (cdb_tag !== 6'd34 || cdb_src !== 2'd2) begin fails++; $display("FAIL sq_bcast2: got tag=%0d src=%0d exp tag=34 src=2", cdb_tag, cdb_src); end
    #1;
    tick();
    req_valid = 4'b0000;
    tests++; if (cdb_tag !== 6'd33 || cdb_src !== 2'd1) begin fails++; $display("FAIL sq_bcast1: got tag=%0d src=%0d exp tag=33 src=1", cdb_tag, cdb_src); end
    tests++; if (conflict_cnt !== 16'd6) begin fails++; $display("FAIL sq_cnt2: got %0d exp 6", conflict_cnt); end
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0100;
    req_tag[12 +: 6] = 6'd7;
    tick();
    req_valid = 4'b0000;
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 6'd7) begin fails++; $display("FAIL ar_pre: got v=%b tag=%0d exp v=1 tag=7", cdb_valid, cdb_tag); end
    #2;
    reset = 1'b0;
    req_valid = 4'b1100;
    #1;
    tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_src !== 2'd0)
      begin fails++; $display("FAIL ar_clear: got v=%b tag=%0d src=%0d exp 0/0/0", cdb_valid, cdb_tag, cdb_src); end
    tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL ar_cnt: got %0d exp 0", conflict_cnt); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL ar_ready: got %b exp 0000", req_ready); end
    @(negedge clock);
    reset = 1'b1;
    req_tag[12 +: 6] = 6'd40;
    req_tag[18 +: 6] = 6'd41;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL ar_grant2: got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    tests++; if (cdb_tag !== 6'd40 || cdb_src !== 2'd2) begin fails++; $display("FAIL ar_bcast2: got tag=%0d src=%0d exp tag=40 src=2", cdb_tag, cdb_src); end
    tests++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL ar_cnt1: got %0d exp 1", conflict_cnt); end
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL ar_grant3: got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tests++; if (cdb_tag !== 6'd41 || cdb_src !== 2'd3) begin fails++; $display("FAIL ar_bcast3: got tag=%0d src=%0d exp tag=41 src=3", cdb_tag, cdb_src); end
    tick();
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL ar_idle: got %b exp 0", cdb_valid); end
  endtask

  initial begin
    reset     = 1'b0;
    squash    = 1'b0;
    req_valid = 4'b0000;
    req_tag   = '0;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_squash();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus among the functional units that complete instructions: ALU, multiplier, load unit and branch unit.
- Each unit presents a completed destination tag with a valid/ready handshake. The arbiter grants one unit per cycle in round-robin order and broadcasts the winning tag on a registered CDB output.
- The reservation stations and map table consume that output for wakeup.
- Sits between the execute-stage units and the rs/map-table/ROB wakeup logic.

Parameters:
- N_REQ, 4, number of requesting functional units; index 0=ALU, 1=MULT, 2=LD, 3=BR.
- TAG_W, 6, physical register tag width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; state cleared while reset==0.
- squash  input  1  branch-mispredict flush; synchronous, active-high.
- req_valid  input  N_REQ  unit i holds a completed result.
- req_tag  input  N_REQ*TAG_W  destination tag of unit i, packed as slice [i*TAG_W +: TAG_W].
- req_ready  output  N_REQ  one-hot grant, combinational; transfer happens when req_valid[i] & req_ready[i].
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast tag (registered).
- cdb_src  output  $clog2(N_REQ)  index of the unit that produced the broadcast (registered).
- conflict_cnt  output  CNT_W  performance counter of contention cycles.

Behaviour:
- Reset (reset==0, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_src=0, rr_ptr=0, conflict_cnt=0.
  - req_ready forced to 0 while reset is asserted.
- Grant (combinational):
  - Scan the requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other req_ready bits are 0.
  - At most one grant per cycle. No request means req_ready=0.
  - If squash=1, req_ready=0 regardless of requests.
- Handshake:
  - A requester holds req_valid and req_tag stable until it sees ready.
  - The arbiter does not latch requests that were not granted.
  - req_valid may drop only after transfer.
- Broadcast (1-cycle latency): at the rising edge ending a cycle with a grant to i:
  - cdb_valid<=1, cdb_tag<=req_tag[i], cdb_src<=i.
  - If that cycle had no grant or squash=1: cdb_valid<=0, and cdb_tag/cdb_src hold their old values.
  - cdb_valid is high for exactly one cycle per transfer.
- Round-robin pointer:
  - After a grant to i, rr_ptr<=(i+1) mod N_REQ. This wraps from N_REQ-1 to 0; N_REQ need not be a power of 2.
  - No grant or squash leaves rr_ptr unchanged.
  - Fairness bound: a continuously valid requester is granted within N_REQ cycles.
- Squash:
  - Kills only that cycle's grant.
  - A broadcast already registered from the previous cycle is still visible in the squash cycle.
  - Requesters drop their own wrong-path valids. The arbiter keeps no request state, so nothing else needs clearing.
- conflict_cnt:
  - Increments by 1 on cycles with popcount(req_valid)>=2 and squash=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Reset mid-operation:
  - Outputs clear immediately, without waiting for a clock edge.
  - An in-flight broadcast is lost.
  - After reset releases, the first grant follows priority from index 0.
- Invariants:
  - $onehot0(req_ready).
  - req_ready[i] implies req_valid[i].
  - cdb_valid implies the previous cycle had a handshake.

Test Plan:
- Reset, then a single request: req_valid=4'b0001, tag 5 -> req_ready=4'b0001 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_src=0; the cycle after, cdb_valid=0.
- All four valid with tags 10,11,12,13, held until each is granted -> grants in order 0,1,2,3 on consecutive cycles; cdb_tag sequence 10,11,12,13 one cycle later; conflict_cnt=3 afterwards (cycles with valid counts 4,3,2).
- Round-robin wrap: rr_ptr=3 after a grant to 2, then req_valid=4'b1001 -> grant 3 first, then 0; rr_ptr ends at 1.
- Squash with req_valid=4'b0110 -> req_ready=0, next cdb_valid=0, rr_ptr unchanged; a broadcast registered in the prior cycle remains visible during the squash cycle.
- Async reset asserted between clock edges while cdb_valid=1 -> cdb_valid=0 and conflict_cnt=0 immediately; after release, req_valid=4'b1100 -> grant to 2.
- Saturation: force conflict_cnt to 16'hFFFE, then 3 cycles of 2 requests each -> counter reads FFFF and stays at FFFF.
